cpu_if: RTL and testbench

CPU_IF -- requirements
Module: cpu_if

---
 rtl/cpu_if.sv | 131 +++++++++++++
 tb/tb_cpu_if.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_if.sv
// Instruction-fetch stage: drives PC to instruction memory, loads IF/ID register.
// Latency: word accepted on imemValid appears in instrD/pcD/validD one clk later.
// Backpressure: stall holds IF/ID; with IF_SKID_BUFFER_EN a stalled word parks in a
//   skid register (HOLD state), otherwise it is dropped and re-fetched from the same PC.
module cpu_if (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branchTake,
  input  logic [15:0] pcBranch,
  output logic [15:0] imemAddr,
  output logic        imemReq,
  input  logic [15:0] imemData,
  input  logic        imemValid,
  output logic [15:0] instrD,
  output logic [15:0] pcD,
  output logic        validD,
  output logic        halted
);

`ifdef IF_SKID_BUFFER_EN
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, HALT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, HALT = 2'd2} state_t;
`endif

  localparam logic [3:0] OP_HLT = 4'hF;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [15:0] pcd_q;
  logic        valid_q;
  logic        req_q;
  logic        halted_q;
`ifdef IF_SKID_BUFFER_EN
  logic [15:0] skid_q;
`endif

  // Address of the instruction after the current PC (16-bit wrap is intentional).
  logic [15:0] pc_inc_d;
  assign pc_inc_d = pc_q + 16'd2;

  assign imemAddr = pc_q;
  assign imemReq  = req_q;
  assign instrD   = instr_q;
  assign pcD      = pcd_q;
  assign validD   = valid_q;
  assign halted   = halted_q;

  // Fetch FSM: branch redirect first, then per-state accept / hold / bubble handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= 16'h0000;
      instr_q  <= 16'h0000;
      pcd_q    <= 16'h0000;
      valid_q  <= 1'b0;
      req_q    <= 1'b1;
      halted_q <= 1'b0;
`ifdef IF_SKID_BUFFER_EN
      skid_q   <= 16'h0000;
`endif
    end else if (branchTake) begin
      // Redirect squashes whatever arrives this cycle and refills from the target.
      state_q  <= FETCH;
      pc_q     <= pcBranch;
      instr_q  <= 16'h0000;
      valid_q  <= 1'b0;
      req_q    <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imemValid && !stall) begin
            instr_q <= imemData;
            pcd_q   <= pc_inc_d;
            valid_q <= 1'b1;
            pc_q    <= pc_inc_d;
            if (imemData[15:12] == OP_HLT) begin
              state_q  <= HALT;
              req_q    <= 1'b0;
              halted_q <= 1'b1;
            end
          end else if (imemValid && stall) begin
`ifdef IF_SKID_BUFFER_EN
            // Park the word so it is not fetched a second time.
            skid_q  <= imemData;
            state_q <= HOLD;
            req_q   <= 1'b0;
`endif
            // Without a skid register the word is dropped; PC stays put for a re-fetch.
          end else if (!stall) begin
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
          end
        end
`ifdef IF_SKID_BUFFER_EN
        HOLD: begin
          if (!stall) begin
            instr_q <= skid_q;
            pcd_q   <= pc_inc_d;
            valid_q <= 1'b1;
            pc_q    <= pc_inc_d;
            if (skid_q[15:12] == OP_HLT) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              state_q  <= FETCH;
              req_q    <= 1'b1;
            end
          end
        end
`endif
        HALT: begin
          // PC frozen; only a branch or reset leaves this state.
          if (!stall) begin
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= FETCH;
          req_q    <= 1'b1;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_if.sv
// Directed bench for cpu_if: reset, streaming fetch, late memory, stall, branch, halt, wrap.
// Works in both builds; stall expectations follow IF_SKID_BUFFER_EN.
module tb_cpu_if;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branchTake;
  logic [15:0] pcBranch;
  logic [15:0] imemAddr;
  logic        imemReq;
  logic [15:0] imemData;
  logic        imemValid;
  logic [15:0] instrD;
  logic [15:0] pcD;
  logic        validD;
  logic        halted;

  int n_asrt = 0;
  int n_fail = 0;

  cpu_if dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .branchTake (branchTake),
    .pcBranch   (pcBranch),
    .imemAddr   (imemAddr),
    .imemReq    (imemReq),
    .imemData   (imemData),
    .imemValid  (imemValid),
    .instrD     (instrD),
    .pcD        (pcD),
    .validD     (validD),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branchTake = 1'b0; pcBranch = 16'h0000;
    imemData = 16'h0000; imemValid = 1'b0;
    #17;
    // Reset state
    chk("rst_addr",   imemAddr, 16'h0000);
    chk("rst_instr",  instrD,   16'h0000);
    chk("rst_pcd",    pcD,      16'h0000);
    chk("rst_valid",  {15'd0, validD}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_req",    {15'd0, imemReq}, 16'd1);
    rst_n = 1'b1;

    // Streaming fetch with zero-latency memory
    imemValid = 1'b1; imemData = 16'h1123;
    chk("s_addr0", imemAddr, 16'h0000);
    tick();
    chk("s_instr1", instrD, 16'h1123);
    chk("s_pcd1",   pcD,    16'h0002);
    chk("s_valid1", {15'd0, validD}, 16'd1);
    chk("s_addr1",  imemAddr, 16'h0002);
    imemData = 16'h2456;
    tick();
    chk("s_instr2", instrD, 16'h2456);
    chk("s_pcd2",   pcD,    16'h0004);
    chk("s_addr2",  imemAddr, 16'h0004);

    // Memory three cycles late: three bubbles, PC holds
    imemValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_valid", {15'd0, validD}, 16'd0);
      chk("late_instr", instrD, 16'h0000);
      chk("late_addr",  imemAddr, 16'h0004);
    end
    imemValid = 1'b1; imemData = 16'h1777;
    tick();
    chk("late_instr_arr", instrD, 16'h1777);
    chk("late_pcd_arr",   pcD,    16'h0006);
    chk("late_addr_arr",  imemAddr, 16'h0006);

    // Word arrives while ID is stalled for two cycles
    imemData = 16'h3321; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stl_addr",  imemAddr, 16'h0006);
      chk("stl_instr", instrD, 16'h1777);
      chk("stl_pcd",   pcD,    16'h0006);
`ifdef IF_SKID_BUFFER_EN
      chk("stl_req", {15'd0, imemReq}, 16'd0);
`else
      chk("stl_req", {15'd0, imemReq}, 16'd1);
`endif
    end
    stall = 1'b0;
`ifdef IF_SKID_BUFFER_EN
    // Bus content is ignored while draining the skid register
    imemValid = 1'b0; imemData = 16'h0BAD;
`endif
    tick();
    chk("stl_rel_instr", instrD, 16'h3321);
    chk("stl_rel_pcd",   pcD,    16'h0008);
    chk("stl_rel_valid", {15'd0, validD}, 16'd1);
    chk("stl_rel_addr",  imemAddr, 16'h0008);
    chk("stl_rel_req",   {15'd0, imemReq}, 16'd1);

    // Branch beats simultaneous data and stall
    branchTake = 1'b1; pcBranch = 16'h0040; imemValid = 1'b1; imemData = 16'h1999; stall = 1'b1;
    tick();
    chk("br_addr",  imemAddr, 16'h0040);
    chk("br_valid", {15'd0, validD}, 16'd0);
    chk("br_instr", instrD, 16'h0000);
    chk("br_req",   {15'd0, imemReq}, 16'd1);
    stall = 1'b0; imemValid = 1'b0;

    // Redirect to 0x000A and fetch HLT
    pcBranch = 16'h000A;
    tick();
    chk("hlt_addr0", imemAddr, 16'h000A);
    branchTake = 1'b0; imemValid = 1'b1; imemData = 16'hF000;
    tick();
    chk("hlt_instr",  instrD, 16'hF000);
    chk("hlt_valid",  {15'd0, validD}, 16'd1);
    chk("hlt_pcd",    pcD, 16'h000C);
    chk("hlt_halted", {15'd0, halted}, 16'd1);
    chk("hlt_req",    {15'd0, imemReq}, 16'd0);
    imemData = 16'h1234;
    tick();
    chk("hlt_bub_valid", {15'd0, validD}, 16'd0);
    chk("hlt_bub_instr", instrD, 16'h0000);
    chk("hlt_frozen",    imemAddr, 16'h000C);
    chk("hlt_still",     {15'd0, halted}, 16'd1);
    imemValid = 1'b0; branchTake = 1'b1; pcBranch = 16'h0000;
    tick();
    chk("hlt_exit_halted", {15'd0, halted}, 16'd0);
    chk("hlt_exit_req",    {15'd0, imemReq}, 16'd1);
    chk("hlt_exit_addr",   imemAddr, 16'h0000);
    branchTake = 1'b0;

    // Load IF/ID, stall a new word, then reset mid-cycle
    imemValid = 1'b1; imemData = 16'h5151;
    tick();
    chk("pre_rst_instr", instrD, 16'h5151);
    chk("pre_rst_pcd",   pcD,    16'h0002);
    imemData = 16'h5555; stall = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr",   imemAddr, 16'h0000);
    chk("arst_instr",  instrD,   16'h0000);
    chk("arst_pcd",    pcD,      16'h0000);
    chk("arst_valid",  {15'd0, validD}, 16'd0);
    chk("arst_halted", {15'd0, halted}, 16'd0);
    chk("arst_req",    {15'd0, imemReq}, 16'd1);
    rst_n = 1'b1; stall = 1'b0; imemValid = 1'b0;
    tick();
    chk("post_rst_addr", imemAddr, 16'h0000);
    chk("post_rst_valid", {15'd0, validD}, 16'd0);

    // PC wrap from 0xFFFE
    branchTake = 1'b1; pcBranch = 16'hFFFE;
    tick();
    chk("wrap_addr0", imemAddr, 16'hFFFE);
    branchTake = 1'b0; imemValid = 1'b1; imemData = 16'h1A1A;
    tick();
    chk("wrap_instr", instrD, 16'h1A1A);
    chk("wrap_pcd",   pcD,    16'h0000);
    chk("wrap_addr",  imemAddr, 16'h0000);
    imemValid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
